// File: rtl/mc_control_unit.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback; MULTICYCLE_MUL_EN enables the MUL funct.
// Latency: datapath controls decode from the state register; 3 to 5 cycles per instruction when memory never stalls.
// Backpressure: mem_ready low holds FETCH, MEMREAD and MEMWRITE; write enables are forced low while rst_n is low.
module mc_control_unit #(
    parameter int opcode_size = 6,
    parameter int funct_size  = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [opcode_size-1:0] Opcode,
    input  logic [funct_size-1:0]  Funct,
    input  logic                   Zero_flag,
    input  logic                   mem_ready,
    output logic                   IorD,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [2:0]             ALUcontrol,
    output logic [1:0]             PCSrc,
    output logic                   RegDst,
    output logic                   MemtoReg,
    output logic                   IRWrite,
    output logic                   MemWrite,
    output logic                   RegWrite,
    output logic                   pc_en,
    output logic                   illegal_op,
    output logic [3:0]             state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEXEC = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [opcode_size-1:0] OP_RTYPE = opcode_size'(6'b000000);
    localparam logic [opcode_size-1:0] OP_LW    = opcode_size'(6'b100011);
    localparam logic [opcode_size-1:0] OP_SW    = opcode_size'(6'b101011);
    localparam logic [opcode_size-1:0] OP_BEQ   = opcode_size'(6'b000100);
    localparam logic [opcode_size-1:0] OP_ADDI  = opcode_size'(6'b001000);
    localparam logic [opcode_size-1:0] OP_J     = opcode_size'(6'b000010);

    localparam logic [funct_size-1:0] FN_ADD = funct_size'(6'b100000);
    localparam logic [funct_size-1:0] FN_SUB = funct_size'(6'b100010);
    localparam logic [funct_size-1:0] FN_AND = funct_size'(6'b100100);
    localparam logic [funct_size-1:0] FN_OR  = funct_size'(6'b100101);
    localparam logic [funct_size-1:0] FN_SLT = funct_size'(6'b101010);
    localparam logic [funct_size-1:0] FN_MUL = funct_size'(6'b011000);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

`ifdef MULTICYCLE_MUL_EN
    localparam logic mul_en = 1'b1;
`else
    localparam logic mul_en = 1'b0;
`endif

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [3:0] dec_next;
    logic       dec_illegal;
    logic       funct_ok;
    logic [2:0] funct_alu;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       pc_write;
    logic       branch;

    // Funct field to ALU op; funct_ok qualifies R-type legality during decode
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (Funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            FN_MUL: begin
                funct_ok  = mul_en;
                funct_alu = mul_en ? ALU_MUL : ALU_ADD;
            end
            default: funct_ok = 1'b0;
        endcase
    end

    // Opcode dispatch out of DECODE; anything unrecognised returns to FETCH flagged illegal
    always_comb begin
        dec_next    = S_FETCH;
        dec_illegal = 1'b0;
        if (Opcode == OP_LW || Opcode == OP_SW)
            dec_next = S_MEMADR;
        else if (Opcode == OP_RTYPE && funct_ok)
            dec_next = S_EXECUTE;
        else if (Opcode == OP_BEQ)
            dec_next = S_BRANCH;
        else if (Opcode == OP_ADDI)
            dec_next = S_ADDIEXEC;
        else if (Opcode == OP_J)
            dec_next = S_JUMP;
        else
            dec_illegal = 1'b1;
    end

    // Next-state logic; memory states wait on mem_ready, unused encodings recover to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = dec_next;
            S_MEMADR:   state_d = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register; reset asynchronously returns to FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    // Per-state datapath controls and raw write enables
    always_comb begin
        IorD       = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUcontrol = ALU_ADD;
        PCSrc      = 2'b00;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB  = 2'b01;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE:   ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD:  IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg  = 1'b1;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUcontrol = funct_alu;
            end
            S_ALUWB: begin
                RegDst    = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUcontrol = ALU_SUB;
                PCSrc      = 2'b01;
                branch     = 1'b1;
            end
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB:   reg_write = 1'b1;
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are masked by rst_n so an aborted instruction cannot commit a write
    assign IRWrite    = rst_n & ir_write;
    assign MemWrite   = rst_n & mem_write;
    assign RegWrite   = rst_n & reg_write;
    assign pc_en      = rst_n & (pc_write | (branch & Zero_flag));
    assign illegal_op = rst_n & (state_q == S_DECODE) & dec_illegal;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

    typedef struct packed {
        logic [3:0] st;
        logic       iord;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] aluc;
        logic [1:0] pcsrc;
        logic       rd;
        logic       m2r;
        logic       irw;
        logic       mw;
        logic       rw;
        logic       pcen;
        logic       ill;
    } exp_t;

    // Hand-derived per-state output vectors (mem_ready=1, Zero_flag=0, legal decode)
    localparam exp_t E0  = {4'd0,  1'b0, 1'b0, 2'b01, 3'b010, 2'b00, 7'b0010010};
    localparam exp_t E1  = {4'd1,  1'b0, 1'b0, 2'b11, 3'b010, 2'b00, 7'b0000000};
    localparam exp_t E2  = {4'd2,  1'b0, 1'b1, 2'b10, 3'b010, 2'b00, 7'b0000000};
    localparam exp_t E3  = {4'd3,  1'b1, 1'b0, 2'b00, 3'b010, 2'b00, 7'b0000000};
    localparam exp_t E4  = {4'd4,  1'b0, 1'b0, 2'b00, 3'b010, 2'b00, 7'b0100100};
    localparam exp_t E5  = {4'd5,  1'b1, 1'b0, 2'b00, 3'b010, 2'b00, 7'b0001000};
    localparam exp_t E6  = {4'd6,  1'b0, 1'b1, 2'b00, 3'b010, 2'b00, 7'b0000000};
    localparam exp_t E7  = {4'd7,  1'b0, 1'b0, 2'b00, 3'b010, 2'b00, 7'b1000100};
    localparam exp_t E8  = {4'd8,  1'b0, 1'b1, 2'b00, 3'b100, 2'b01, 7'b0000000};
    localparam exp_t E9  = {4'd9,  1'b0, 1'b1, 2'b10, 3'b010, 2'b00, 7'b0000000};
    localparam exp_t E10 = {4'd10, 1'b0, 1'b0, 2'b00, 3'b010, 2'b00, 7'b0000100};
    localparam exp_t E11 = {4'd11, 1'b0, 1'b0, 2'b00, 3'b010, 2'b10, 7'b0000010};

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Opcode, Funct;
    logic       Zero_flag, mem_ready;
    logic       IorD, ALUSrcA, RegDst, MemtoReg, IRWrite, MemWrite, RegWrite, pc_en, illegal_op;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUcontrol;
    logic [3:0] state;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t  exp_q[$];
    string name_q[$];

    mc_control_unit #(.opcode_size(6), .funct_size(6)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct),
        .Zero_flag(Zero_flag), .mem_ready(mem_ready),
        .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUcontrol(ALUcontrol),
        .PCSrc(PCSrc), .RegDst(RegDst), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .pc_en(pc_en),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    function automatic exp_t actual();
        exp_t a;
        a = {state, IorD, ALUSrcA, ALUSrcB, ALUcontrol, PCSrc, RegDst, MemtoReg,
             IRWrite, MemWrite, RegWrite, pc_en, illegal_op};
        return a;
    endfunction

    task automatic check(input string nm, input exp_t act, input exp_t req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got state=%0d vec=%h, required state=%0d vec=%h",
                     nm, act.st, act, req.st, req);
        end
    endtask

    function automatic exp_t s0(input logic mr);
        exp_t e = E0;
        e.irw  = mr;
        e.pcen = mr;
        return e;
    endfunction

    function automatic exp_t s1_ill();
        exp_t e = E1;
        e.ill = 1'b1;
        return e;
    endfunction

    function automatic exp_t s6(input logic [2:0] op);
        exp_t e = E6;
        e.aluc = op;
        return e;
    endfunction

    function automatic exp_t s8(input logic z);
        exp_t e = E8;
        e.pcen = z;
        return e;
    endfunction

    // One clock of stimulus: drive inputs after the edge and queue the expected outputs
    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic mr, input exp_t e, input string nm);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        Opcode    = op;
        Funct     = fn;
        Zero_flag = z;
        mem_ready = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare the DUT against the oldest expectation at each falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, actual(), e);
        end
    end

    initial begin
        rst_n = 1'b0; Opcode = OP_LW; Funct = 6'd0; Zero_flag = 1'b0; mem_ready = 1'b1;

        // Reset held with mem_ready high: S0 outputs, enables suppressed
        @(posedge clk);
        #1;
        exp_q.push_back(s0(1'b0));
        name_q.push_back("reset_hold");

        // lw with two stall cycles in MEMREAD (first fetch right after reset release)
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, E0, "lw_fetch");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, E1, "lw_decode");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, E2, "lw_memadr");
        cyc(OP_LW, 6'd0, 1'b0, 1'b0, E3, "lw_memrd_stall1");
        cyc(OP_LW, 6'd0, 1'b0, 1'b0, E3, "lw_memrd_stall2");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, E3, "lw_memrd_done");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, E4, "lw_memwb");

        // R-type sub and slt
        cyc(OP_R, 6'b100010, 1'b0, 1'b1, E0, "sub_fetch");
        cyc(OP_R, 6'b100010, 1'b0, 1'b1, E1, "sub_decode");
        cyc(OP_R, 6'b100010, 1'b0, 1'b1, s6(3'b100), "sub_exec");
        cyc(OP_R, 6'b100010, 1'b0, 1'b1, E7, "sub_wb");
        cyc(OP_R, 6'b101010, 1'b0, 1'b1, E0, "slt_fetch");
        cyc(OP_R, 6'b101010, 1'b0, 1'b1, E1, "slt_decode");
        cyc(OP_R, 6'b101010, 1'b0, 1'b1, s6(3'b110), "slt_exec");
        cyc(OP_R, 6'b101010, 1'b0, 1'b1, E7, "slt_wb");

        // beq taken / not taken; Zero_flag only matters in BRANCH
        cyc(OP_BEQ, 6'd0, 1'b1, 1'b1, E0, "beq1_fetch");
        cyc(OP_BEQ, 6'd0, 1'b1, 1'b1, E1, "beq1_decode");
        cyc(OP_BEQ, 6'd0, 1'b1, 1'b1, s8(1'b1), "beq1_taken");
        cyc(OP_BEQ, 6'd0, 1'b0, 1'b1, E0, "beq0_fetch");
        cyc(OP_BEQ, 6'd0, 1'b0, 1'b1, E1, "beq0_decode");
        cyc(OP_BEQ, 6'd0, 1'b0, 1'b1, s8(1'b0), "beq0_nottaken");

        // Illegal opcode: pulse in DECODE, back to FETCH
        cyc(OP_BAD, 6'd0, 1'b0, 1'b1, E0, "badop_fetch");
        cyc(OP_BAD, 6'd0, 1'b0, 1'b1, s1_ill(), "badop_decode");

        // Multiply funct depends on build option
        cyc(OP_R, 6'b011000, 1'b0, 1'b1, E0, "mul_fetch");
`ifdef MULTICYCLE_MUL_EN
        cyc(OP_R, 6'b011000, 1'b0, 1'b1, E1, "mul_decode");
        cyc(OP_R, 6'b011000, 1'b0, 1'b1, s6(3'b101), "mul_exec");
        cyc(OP_R, 6'b011000, 1'b0, 1'b1, E7, "mul_wb");
`else
        cyc(OP_R, 6'b011000, 1'b0, 1'b1, s1_ill(), "mul_illegal");
`endif

        // sw without stalls, then sw with fetch and write stalls
        cyc(OP_SW, 6'd0, 1'b0, 1'b1, E0, "sw_fetch");
        cyc(OP_SW, 6'd0, 1'b0, 1'b1, E1, "sw_decode");
        cyc(OP_SW, 6'd0, 1'b0, 1'b1, E2, "sw_memadr");
        cyc(OP_SW, 6'd0, 1'b0, 1'b1, E5, "sw_memwr");
        cyc(OP_SW, 6'd0, 1'b0, 1'b0, s0(1'b0), "sw2_fetch_stall");
        cyc(OP_SW, 6'd0, 1'b0, 1'b1, E0, "sw2_fetch");
        cyc(OP_SW, 6'd0, 1'b0, 1'b1, E1, "sw2_decode");
        cyc(OP_SW, 6'd0, 1'b0, 1'b1, E2, "sw2_memadr");
        cyc(OP_SW, 6'd0, 1'b0, 1'b0, E5, "sw2_memwr_stall");
        cyc(OP_SW, 6'd0, 1'b0, 1'b1, E5, "sw2_memwr");

        // j and addi
        cyc(OP_J, 6'd0, 1'b0, 1'b1, E0, "j_fetch");
        cyc(OP_J, 6'd0, 1'b0, 1'b1, E1, "j_decode");
        cyc(OP_J, 6'd0, 1'b0, 1'b1, E11, "j_jump");
        cyc(OP_ADDI, 6'd0, 1'b0, 1'b1, E0, "addi_fetch");
        cyc(OP_ADDI, 6'd0, 1'b0, 1'b1, E1, "addi_decode");
        cyc(OP_ADDI, 6'd0, 1'b0, 1'b1, E9, "addi_exec");
        cyc(OP_ADDI, 6'd0, 1'b0, 1'b1, E10, "addi_wb");

        // lw aborted by reset in the middle of MEMWB
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, E0, "lwab_fetch");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, E1, "lwab_decode");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, E2, "lwab_memadr");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, E3, "lwab_memrd");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, E4, "lwab_memwb");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_memwb", actual(), s0(1'b0));

        // Recovery after the abort: j then return to FETCH
        cyc(OP_J, 6'd0, 1'b0, 1'b1, E0, "rec_fetch");
        cyc(OP_J, 6'd0, 1'b0, 1'b1, E1, "rec_decode");
        cyc(OP_J, 6'd0, 1'b0, 1'b1, E11, "rec_jump");
        cyc(OP_J, 6'd0, 1'b0, 1'b0, s0(1'b0), "rec_back_to_fetch");

        // Every queued expectation must have been consumed by the monitor
        @(negedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
